mul_operand_issuer: RTL and testbench

//  Upstream feeder for the shift-and-add multiplier (MUL).
//  - Buffers (a,b) operand pairs from a valid/ready producer in a small FIFO.
//  - Issues them one at a time to MUL as a one-cycle in_valid pulse.
//  - Holds MUL's operand inputs stable, then waits for out_valid before issuing the next pair.
//  - MUL has no ready signal; this block guarantees it never receives in_valid while an operation is in flight.

---
 rtl/mul_issue_pkg.sv | 19 +
 rtl/mul_issue_fifo.sv | 63 ++++++
 rtl/mul_operand_issuer.sv | 128 ++++++++++++
 tb/tb_mul_operand_issuer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_issue_pkg.sv
// Shared types for the multiplier operand issuer.
// Operand width constants, operand pair bundle and issue FSM states.
package mul_issue_pkg;

    localparam int WIDTH_LOG = 2;
    localparam int WIDTH     = 1 << WIDTH_LOG;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } operand_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/mul_issue_fifo.sv
// Operand pair FIFO: synchronous write, combinational head read.
// Push is ignored when full and pop is ignored when empty.
module mul_issue_fifo
    import mul_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  operand_t               wdata,
    output operand_t               rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    operand_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Storage write; contents need no reset since cnt gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth; occupancy tracks both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mul_operand_issuer.sv
// Feeds buffered operand pairs to a ready-less multiplier, one op in flight.
// Optional WAIT timeout with sticky err port: define MUL_ISSUE_TIMEOUT_EN.
module mul_operand_issuer
    import mul_issue_pkg::*;
#(
    parameter int DEPTH   = 4
`ifdef MUL_ISSUE_TIMEOUT_EN
   ,parameter int TIMEOUT = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_a,
    input  logic [WIDTH-1:0]       s_b,
    output logic                   mul_in_valid,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_out_valid,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
`ifdef MUL_ISSUE_TIMEOUT_EN
   ,output logic                   err
`endif
);

    issue_state_t state_q;
    issue_state_t state_d;
    operand_t     head;
    operand_t     wdata;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         timeout;

    assign s_ready = !fifo_full;
    assign push    = s_valid && s_ready;
    assign wdata   = '{a: s_a, b: s_b};
    assign busy    = (state_q != IDLE);

    mul_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

`ifdef MUL_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q;
    logic          err_q;

    assign timeout = (state_q == WAIT) && (wait_cnt_q == TW'(TIMEOUT - 1));
    assign err     = err_q;

    // WAIT cycle counter, cleared while issuing; sticky err on a missed finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (timeout && !mul_out_valid) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next state and pop; finishes outside WAIT are stale and ignored.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_out_valid || timeout) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, one-cycle start pulse and operand hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mul_in_valid <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
        end else begin
            state_q      <= state_d;
            mul_in_valid <= pop;
            if (pop) begin
                mul_a <= head.a;
                mul_b <= head.b;
            end
        end
    end

endmodule

// File: tb/tb_mul_operand_issuer.sv
// Directed self-checking bench for mul_operand_issuer.
// Timeout scenario is built only when MUL_ISSUE_TIMEOUT_EN is defined.
module tb_mul_operand_issuer;
    import mul_issue_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
    logic             mul_in_valid;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_out_valid;
    logic             busy;
    logic [2:0]       count;
`ifdef MUL_ISSUE_TIMEOUT_EN
    logic             err;
`endif

    int passed = 0;
    int total  = 0;

    mul_operand_issuer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_a           (s_a),
        .s_b           (s_b),
        .mul_in_valid  (mul_in_valid),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_out_valid (mul_out_valid),
        .busy          (busy),
        .count         (count)
`ifdef MUL_ISSUE_TIMEOUT_EN
       ,.err           (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt [5] = '{1, 1, 2, 3, 4};
        int n;
        int pushed;
        int issued;
        int wd;
        logic acc;

        rst_n         = 1'b1;
        s_valid       = 1'b0;
        s_a           = '0;
        s_b           = '0;
        mul_out_valid = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        check("rst_count", count, 0);
        check("rst_ready", s_ready, 1);
        check("rst_inv", mul_in_valid, 0);
        check("rst_a", mul_a, 0);
        check("rst_b", mul_b, 0);
        check("rst_busy", busy, 0);
`ifdef MUL_ISSUE_TIMEOUT_EN
        check("rst_err", err, 0);
`endif

        // 1: single op
        s_valid = 1'b1;
        s_a = 4'd3;
        s_b = 4'd5;
        check("t1_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        check("t1_e0_count", count, 1);
        check("t1_e0_inv", mul_in_valid, 0);
        tick();
        check("t1_e1_inv", mul_in_valid, 1);
        check("t1_e1_a", mul_a, 3);
        check("t1_e1_b", mul_b, 5);
        check("t1_e1_busy", busy, 1);
        check("t1_e1_count", count, 0);
        tick();
        check("t1_e2_inv", mul_in_valid, 0);
        check("t1_e2_a", mul_a, 3);
        check("t1_e2_busy", busy, 1);
        tick();
        tick();
        tick();
        check("t1_e5_busy", busy, 1);
        check("t1_e5_inv", mul_in_valid, 0);
        mul_out_valid = 1'b1;
        tick();
        mul_out_valid = 1'b0;
        check("t1_e6_busy", busy, 0);
        tick();
        check("t1_e7_inv", mul_in_valid, 0);

        // 2: back-to-back fill
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_a = WIDTH'(10 + i);
            s_b = WIDTH'(1 + i);
            check("t2_ready", s_ready, 1);
            tick();
            check("t2_count", count, exp_cnt[i]);
        end
        check("t2_full_ready", s_ready, 0);
        s_a = 4'd15;
        s_b = 4'd6;
        tick();
        s_valid = 1'b0;
        check("t2_refused_count", count, 4);
        check("t2_held_a", mul_a, 10);
        check("t2_held_b", mul_b, 1);
        mul_out_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (mul_in_valid) begin
                check("t2_order_a", mul_a, 11 + n);
                check("t2_order_b", mul_b, 2 + n);
                n++;
            end
            if (n >= 4 && !busy && count == 0) break;
        end
        mul_out_valid = 1'b0;
        check("t2_drained", n, 4);
        check("t2_end_count", count, 0);
        check("t2_end_busy", busy, 0);

        // 3: ordered stream across pointer wrap
        pushed = 0;
        issued = 0;
        wd     = 0;
        for (int c = 0; c < 300; c++) begin
            if (pushed == 10 && issued == 10 && !busy) break;
            s_valid = (pushed < 10);
            s_a = WIDTH'(pushed);
            s_b = WIDTH'(pushed + 1);
            mul_out_valid = (wd == 1);
            if (wd > 0) wd--;
            acc = s_valid && s_ready;
            tick();
            if (acc) pushed++;
            if (mul_in_valid) begin
                check("t3_a", mul_a, issued);
                check("t3_b", mul_b, issued + 1);
                issued++;
                wd = 2;
            end
        end
        s_valid = 1'b0;
        mul_out_valid = 1'b0;
        check("t3_pushed", pushed, 10);
        check("t3_pulses", issued, 10);
        check("t3_count", count, 0);

        // 4: spurious finish while idle and empty
        tick();
        mul_out_valid = 1'b1;
        tick();
        mul_out_valid = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_inv", mul_in_valid, 0);
        check("t4_count", count, 0);
        tick();
        check("t4_inv_late", mul_in_valid, 0);
        check("t4_busy_late", busy, 0);

        // 5: reset during WAIT with two queued
        for (int i = 1; i <= 3; i++) begin
            s_valid = 1'b1;
            s_a = WIDTH'(i);
            s_b = WIDTH'(i + 1);
            tick();
        end
        s_valid = 1'b0;
        check("t5_pre_count", count, 2);
        check("t5_pre_busy", busy, 1);
        check("t5_pre_inv", mul_in_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_count", count, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_inv", mul_in_valid, 0);
        check("t5_rst_ready", s_ready, 1);
        check("t5_rst_a", mul_a, 0);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mul_in_valid || busy) n++;
        end
        check("t5_quiet", n, 0);
        s_valid = 1'b1;
        s_a = 4'd7;
        s_b = 4'd9;
        tick();
        s_valid = 1'b0;
        tick();
        check("t5_new_inv", mul_in_valid, 1);
        check("t5_new_a", mul_a, 7);
        check("t5_new_b", mul_b, 9);
        tick();
        mul_out_valid = 1'b1;
        tick();
        mul_out_valid = 1'b0;
        check("t5_done_busy", busy, 0);

`ifdef MUL_ISSUE_TIMEOUT_EN
        // 6: timeout with a queued follower
        s_valid = 1'b1;
        s_a = 4'd5;
        s_b = 4'd6;
        tick();
        s_a = 4'd6;
        s_b = 4'd7;
        tick();
        s_valid = 1'b0;
        check("t6_inv", mul_in_valid, 1);
        check("t6_a", mul_a, 5);
        tick();
        repeat (15) tick();
        check("t6_e17_busy", busy, 1);
        check("t6_e17_err", err, 0);
        tick();
        check("t6_e18_busy", busy, 0);
        check("t6_e18_err", err, 1);
        tick();
        check("t6_next_inv", mul_in_valid, 1);
        check("t6_next_a", mul_a, 6);
        check("t6_next_err", err, 1);
        tick();
        mul_out_valid = 1'b1;
        tick();
        mul_out_valid = 1'b0;
        check("t6_done_busy", busy, 0);
        check("t6_sticky_err", err, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
